// File: rtl/fifo_apb_pkg.sv
// Shared constants and FSM encoding for the FIFO APB arbiter.
package fifo_apb_pkg;

  localparam int unsigned ADDR_PUSH = 1;
  localparam int unsigned ADDR_POP  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fifo_rr_grant.sv
// One-hot grant selection for the FIFO APB arbiter.
// FIFO_ARB_RR_EN selects round-robin with a last-grant pointer; otherwise fixed priority.
module fifo_rr_grant #(
  parameter int unsigned NREQ = 2
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic [NREQ-1:0] req_vec,
  input  logic            update,
  output logic [NREQ-1:0] gnt_onehot
);

`ifdef FIFO_ARB_RR_EN
  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;
  int unsigned   idx;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    gnt_onehot = '0;
    ptr_d      = ptr_q;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && req_vec[PW'(idx)]) begin
        gnt_onehot[PW'(idx)] = 1'b1;
        ptr_d                = PW'(idx);
        found                = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ptr_q <= PW'(NREQ - 1);
    end else if (update) begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused;
  assign unused = ^{PCLK, PRESET, update};

  // Isolate the lowest set request bit.
  assign gnt_onehot = req_vec & (~req_vec + NREQ'(1));
`endif

endmodule

// File: rtl/fifo_apb_arbiter.sv
// Arbitrates NREQ push/pop requesters onto the APB port of the FIFO slave.
// Arbitration mode follows FIFO_ARB_RR_EN (see fifo_rr_grant).
module fifo_apb_arbiter
  import fifo_apb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ-1:0][WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [WIDTH-1:0]           PADDR,
  output logic [WIDTH-1:0]           PWDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR,
  input  logic [WIDTH-1:0]           PRDATA
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

  arb_state_t        state_q;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic              grant_en;
  logic [IDW-1:0]    id_q;
  logic [CNTW-1:0]   cnt_q;
  logic [CNTW-1:0]   cnt_d;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [WIDTH-1:0]  paddr_q;
  logic [WIDTH-1:0]  pwdata_q;
  logic [NREQ-1:0]   req_ready_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [WIDTH-1:0]  rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  fifo_rr_grant #(.NREQ(NREQ)) u_grant (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req_vec    (req_valid),
    .update     (grant_en),
    .gnt_onehot (gnt)
  );

  // A new transfer may start from IDLE or on the completing ACCESS cycle.
  assign grant_en = (|req_valid) && ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));

  always_comb begin
    gnt_id = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_id = IDW'(i);
    end
  end

  assign cnt_d = (cnt_q == CNTW'(TIMEOUT)) ? cnt_q : cnt_q + CNTW'(1);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      id_q          <= '0;
      cnt_q         <= '0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= id_q;
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            rsp_err_q     <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
          end else if (cnt_d == CNTW'(TIMEOUT)) begin
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= id_q;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A grant overrides the IDLE return above for back-to-back transfers.
      if (grant_en) begin
        req_ready_q <= gnt;
        id_q        <= gnt_id;
        cnt_q       <= '0;
        state_q     <= SETUP;
        psel_q      <= 1'b1;
        penable_q   <= 1'b0;
        pwrite_q    <= req_write[gnt_id];
        paddr_q     <= req_write[gnt_id] ? WIDTH'(ADDR_PUSH) : WIDTH'(ADDR_POP);
        pwdata_q    <= req_wdata[gnt_id];
      end
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
